clkdiv_reset_ctl: RTL and testbench
===================================

Name: clkdiv_reset_ctl

Overview:
Parametrised reset sequencer and multi-channel clock divider for the out_clk domain, following the DCM-based clock generators. It synchronises and filters the DCM lock indication and releases a stretched synchronous reset. It provides NUM_DIV independent runtime-programmable dividers, each with a 50%-duty toggle output and a single-cycle strobe output, for UART baud generation, timers and similar uses. It also records loss-of-lock events and re-enters reset automatically when lock is lost.

Parameters:
NUM_DIV, 2, number of divider channels (1..16)
DIV_WIDTH, 16, width of each channel's terminal-count value
LOCK_FILTER, 4, consecutive synchronised locked=1 cycles required before lock is treated as stable (>=1)
RESET_STRETCH, 8, out_clk cycles out_reset is held after stable lock (>=1)

Ports:
out_clk  in  1  system clock; all logic is clocked on its rising edge
in_reset  in  1  asynchronous active-high reset
in_locked  in  1  DCM lock, asynchronous to out_clk
div_value  in  NUM_DIV*DIV_WIDTH  per-channel terminal count T; channel i uses bits [i*DIV_WIDTH +: DIV_WIDTH]
div_enable  in  NUM_DIV  per-channel run enable
lock_lost_clear  in  1  single-cycle clear for lock_lost
out_reset  out  1  synchronous active-high system reset
out_div_clk  out  NUM_DIV  divided clock per channel, toggle output (fabric signal, not a BUFG clock)
out_div_stb  out  NUM_DIV  one-cycle strobe per channel at each terminal count
lock_lost  out  1  sticky flag: lock dropped while in RUN

Behaviour:
- Reset: reset is in_reset, asynchronous, active-high; clock is out_clk. In reset, out_reset=1, out_div_clk=0, out_div_stb=0, lock_lost=0, all counters=0, the synchroniser is 0 and the state is RESET.
- Lock synchroniser: in_locked passes through 2 flip-flops to give lk_s.
- Lock filter:
  - Counter lf counts consecutive lk_s=1 cycles and saturates at LOCK_FILTER.
  - stable = (lf==LOCK_FILTER).
  - lk_s=0 clears lf to 0 in the same cycle, so stable drops the next cycle.
- State machine (out_reset=1 in every state except RUN):
  - RESET: go to WAIT_LOCK on the first clock after in_reset is released.
  - WAIT_LOCK: when stable=1, load the stretch counter with RESET_STRETCH-1 and go to STRETCH.
  - STRETCH:
    - lk_s=0 returns to WAIT_LOCK.
    - Otherwise the counter decrements; at 0, go to RUN.
  - RUN:
    - out_reset is registered 0.
    - lk_s=0 returns to WAIT_LOCK, with out_reset=1 from the next edge, and sets lock_lost.
- Release timing: with in_locked already 1 at reset release, out_reset falls exactly 1+2+LOCK_FILTER+RESET_STRETCH edges after the first edge following release. Default parameters: 15 edges.
- lock_lost:
  - Set on the RUN to WAIT_LOCK transition.
  - Cleared by lock_lost_clear.
  - If set and clear occur in the same cycle, set wins.
- Divider channel i (independent per channel):
  - Run condition: runs only when out_reset=0 and div_enable[i]=1. Otherwise the counter is 0, out_div_clk[i] is 0 and out_div_stb[i] is 0, all registered.
  - Counting:
    - Counter c counts 0..T.
    - When c>=T: c<=0, out_div_clk[i] toggles, and out_div_stb[i]=1 for that one cycle.
    - Otherwise c<=c+1 and out_div_stb[i]=0.
  - Period: strobe period is T+1 cycles; out_div_clk period is 2*(T+1) cycles at 50% duty.
  - T=0: strobe is high every cycle and out_div_clk toggles every cycle.
  - Runtime change of div_value is sampled every cycle. If the new T is <= the current c, the channel wraps on the next edge (the >= compare), so there is no 2^DIV_WIDTH lockout.
  - On enable rising, the first strobe occurs T+1 edges later.
  - Arithmetic is unsigned DIV_WIDTH; c never exceeds max(T, previous T).
- Lock loss in RUN:
  - out_reset reasserts, so all channels clear the following edge.
  - Channels restart from 0 when out_reset falls again.
- Asynchronous in_reset mid-operation forces all outputs to their reset values immediately.

Test Plan:
- Power-up: in_locked=1, release in_reset -> out_reset falls after exactly 15 edges (defaults); lock_lost=0.
- Lock filter: in_locked pulses 1 for 3 cycles then 0 after sync -> remains in WAIT_LOCK; out_reset stays 1; lf restarts from 0.
- Lock loss in RUN: drop in_locked for 1 cycle -> out_reset=1 three edges later (2 sync + 1); lock_lost=1 and sticky; out_div_clk=0. Then lock_lost_clear together with a new loss event -> lock_lost stays 1.
- Divide by 54: T=53, enable ch0 -> out_div_stb[0] every 54 cycles; out_div_clk[0] period 108, high 54 / low 54. T=0 on ch1 -> stb constant 1, clk toggles every cycle.
- Runtime shrink: ch0 at c=40 with T=53, change T to 10 -> wrap on next edge with a strobe, then period 11.
- Enable gating plus async reset: deassert div_enable[1] mid-count -> outputs 0 next edge; re-enable with T=3 -> first strobe 4 edges later. Assert in_reset mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/clkdiv_reset_ctl.sv
// Lock-filtered reset sequencer with NUM_DIV programmable toggle/strobe dividers.
// All logic runs on out_clk; in_reset is asynchronous active-high.
module clkdiv_reset_ctl #(
  parameter int NUM_DIV       = 2,
  parameter int DIV_WIDTH     = 16,
  parameter int LOCK_FILTER   = 4,
  parameter int RESET_STRETCH = 8
) (
  input  logic                         out_clk,
  input  logic                         in_reset,
  input  logic                         in_locked,
  input  logic [NUM_DIV*DIV_WIDTH-1:0] div_value,
  input  logic [NUM_DIV-1:0]           div_enable,
  input  logic                         lock_lost_clear,
  output logic                         out_reset,
  output logic [NUM_DIV-1:0]           out_div_clk,
  output logic [NUM_DIV-1:0]           out_div_stb,
  output logic                         lock_lost
);

  localparam int LFW = $clog2(LOCK_FILTER + 1);
  localparam int SCW =
    (RESET_STRETCH > 1) ? $clog2(RESET_STRETCH) : 1;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_WAIT,
    ST_STRETCH,
    ST_RUN
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [LFW-1:0]       lf_q, lf_d;
  logic [SCW-1:0]       sc_q, sc_d;
  logic                 rst_q, rst_d;
  logic                 lost_q, lost_d;
  logic [DIV_WIDTH-1:0] cnt_q [NUM_DIV];
  logic [DIV_WIDTH-1:0] cnt_d [NUM_DIV];
  logic [NUM_DIV-1:0]   dclk_q, dclk_d;
  logic [NUM_DIV-1:0]   stb_q, stb_d;
  logic                 lk_s;
  logic                 stable;
  logic [DIV_WIDTH-1:0] tv;

  assign lk_s   = sync_q[1];
  assign stable = (lf_q == LFW'(LOCK_FILTER));

  always_comb begin
    sync_d  = {sync_q[0], in_locked};
    lf_d    = '0;
    if (lk_s)
      lf_d = stable ? lf_q : lf_q + LFW'(1);
    state_d = state_q;
    sc_d    = sc_q;
    lost_d  = lock_lost_clear ? 1'b0 : lost_q;
    unique case (state_q)
      ST_RESET: state_d = ST_WAIT;
      ST_WAIT: begin
        if (stable) begin
          sc_d    = SCW'(RESET_STRETCH - 1);
          state_d = ST_STRETCH;
        end
      end
      ST_STRETCH: begin
        if (!lk_s)
          state_d = ST_WAIT;
        else if (sc_q == '0)
          state_d = ST_RUN;
        else
          sc_d = sc_q - SCW'(1);
      end
      ST_RUN: begin
        // a new loss outranks a simultaneous clear
        if (!lk_s) begin
          state_d = ST_WAIT;
          lost_d  = 1'b1;
        end
      end
      default: state_d = ST_RESET;
    endcase
    rst_d = (state_d != ST_RUN);
  end

  always_comb begin
    tv     = '0;
    dclk_d = '0;
    stb_d  = '0;
    for (int i = 0; i < NUM_DIV; i++) begin
      tv       = div_value[i*DIV_WIDTH +: DIV_WIDTH];
      cnt_d[i] = '0;
      if (!rst_q && div_enable[i]) begin
        // >= so a shrunk T below the count wraps at once
        if (cnt_q[i] >= tv) begin
          dclk_d[i] = ~dclk_q[i];
          stb_d[i]  = 1'b1;
        end else begin
          cnt_d[i]  = cnt_q[i] + DIV_WIDTH'(1);
          dclk_d[i] = dclk_q[i];
        end
      end
    end
  end

  always_ff @(posedge out_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q <= ST_RESET;
      sync_q  <= '0;
      lf_q    <= '0;
      sc_q    <= '0;
      rst_q   <= 1'b1;
      lost_q  <= 1'b0;
      dclk_q  <= '0;
      stb_q   <= '0;
      for (int i = 0; i < NUM_DIV; i++)
        cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      lf_q    <= lf_d;
      sc_q    <= sc_d;
      rst_q   <= rst_d;
      lost_q  <= lost_d;
      dclk_q  <= dclk_d;
      stb_q   <= stb_d;
      for (int i = 0; i < NUM_DIV; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_reset   = rst_q;
  assign lock_lost   = lost_q;
  assign out_div_clk = dclk_q;
  assign out_div_stb = stb_q;

endmodule

// File: tb/tb_clkdiv_reset_ctl.sv
// Bench for clkdiv_reset_ctl: directed scenarios plus random stimulus,
// every cycle compared against a phase/elapsed-time reference model.
module tb_clkdiv_reset_ctl;

  localparam int ND = 2;
  localparam int DW = 16;
  localparam int LF = 4;
  localparam int RS = 8;

  logic out_clk = 1'b0;
  logic in_reset = 1'b1;
  logic in_locked = 1'b0;
  logic lock_lost_clear = 1'b0;
  logic [ND*DW-1:0] div_value = '0;
  logic [ND-1:0] div_enable = '0;
  logic out_reset, lock_lost;
  logic [ND-1:0] out_div_clk, out_div_stb;

  int total = 0;
  int bad = 0;

  always #5 out_clk = ~out_clk;

  clkdiv_reset_ctl #(
    .NUM_DIV(ND), .DIV_WIDTH(DW),
    .LOCK_FILTER(LF), .RESET_STRETCH(RS)
  ) dut (
    .out_clk(out_clk),
    .in_reset(in_reset),
    .in_locked(in_locked),
    .div_value(div_value),
    .div_enable(div_enable),
    .lock_lost_clear(lock_lost_clear),
    .out_reset(out_reset),
    .out_div_clk(out_div_clk),
    .out_div_stb(out_div_stb),
    .lock_lost(lock_lost)
  );

  // model: ph 0=reset 1=wait-lock 2=stretch 3=run
  bit m_s0, m_s1;
  int ones, ph, left;
  bit m_lost, m_rst;
  int el [ND];
  logic [ND-1:0] m_clk, m_stb;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic mreset();
    m_s0 = 0; m_s1 = 0; ones = 0; ph = 0; left = 0;
    m_lost = 0; m_rst = 1; m_clk = '0; m_stb = '0;
    for (int i = 0; i < ND; i++) el[i] = 0;
  endtask

  task automatic medge();
    bit lk, st, rs_pre;
    int t;
    lk = m_s1;
    st = (ones >= LF);
    rs_pre = m_rst;
    m_s1 = m_s0;
    m_s0 = in_locked;
    ones = lk ? ones + 1 : 0;
    if (lock_lost_clear) m_lost = 0;
    case (ph)
      0: ph = 1;
      1: if (st) begin ph = 2; left = RS; end
      2: if (!lk) ph = 1;
         else begin left--; if (left == 0) ph = 3; end
      default: if (!lk) begin ph = 1; m_lost = 1; end
    endcase
    m_rst = (ph != 3);
    for (int i = 0; i < ND; i++) begin
      t = int'(div_value[i*DW +: DW]);
      if (!rs_pre && div_enable[i]) begin
        // el = edges since last strobe; strobe each T+1 edges
        if (el[i] >= t) begin
          el[i] = 0; m_clk[i] = ~m_clk[i]; m_stb[i] = 1;
        end else begin
          el[i]++; m_stb[i] = 0;
        end
      end else begin
        el[i] = 0; m_clk[i] = 0; m_stb[i] = 0;
      end
    end
  endtask

  task automatic cmp();
    chk("out_reset", 32'(out_reset), 32'(m_rst));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("div_clk", 32'(out_div_clk), 32'(m_clk));
    chk("div_stb", 32'(out_div_stb), 32'(m_stb));
  endtask

  task automatic step();
    @(posedge out_clk);
    if (in_reset) mreset();
    else medge();
    #1;
    cmp();
  endtask

  task automatic set_t(input int i, input int v);
    div_value[i*DW +: DW] = DW'(v);
  endtask

  task automatic wait_run(input string tag);
    for (int k = 0; k < 80 && out_reset !== 1'b0; k++) step();
    chk(tag, 32'(out_reset), 0);
  endtask

  task automatic areset();
    #2;
    in_reset = 1'b1;
    mreset();
    #1;
    cmp();
  endtask

  int n, s0, h0, s1, rcnt;

  initial begin
    mreset();
    in_locked = 1'b1;
    repeat (3) step();
    #2 in_reset = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && out_reset !== 1'b0; k++) begin
      step(); n++;
    end
    chk("release_edges", n, 15);
    chk("lost_powerup", 32'(lock_lost), 0);

    set_t(0, 53); set_t(1, 0); div_enable = 2'b11;
    s0 = 0; h0 = 0; s1 = 0;
    repeat (216) begin
      step();
      s0 += int'(out_div_stb[0]);
      h0 += int'(out_div_clk[0]);
      s1 += int'(out_div_stb[1]);
    end
    chk("stb0_count", s0, 4);
    chk("clk0_high", h0, 108);
    chk("stb1_count", s1, 216);

    for (int k = 0; k < 60 && el[0] != 40; k++) step();
    chk("at_c40", el[0], 40);
    set_t(0, 10);
    step();
    chk("shrink_wrap", 32'(out_div_stb[0]), 1);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      step(); n++;
      if (out_div_stb[0]) break;
    end
    chk("shrink_period", n, 11);

    set_t(1, 3);
    repeat (5) step();
    div_enable[1] = 1'b0;
    step();
    chk("gate_clk", 32'(out_div_clk[1]), 0);
    chk("gate_stb", 32'(out_div_stb[1]), 0);
    repeat (3) step();
    div_enable[1] = 1'b1;
    n = 0;
    for (int k = 0; k < 20; k++) begin
      step(); n++;
      if (out_div_stb[1]) break;
    end
    chk("en_first_stb", n, 4);

    in_locked = 1'b0;
    step();
    in_locked = 1'b1;
    n = 1;
    for (int k = 0; k < 10 && out_reset !== 1'b1; k++) begin
      step(); n++;
    end
    chk("loss_latency", n, 3);
    chk("loss_flag", 32'(lock_lost), 1);
    step();
    chk("loss_divclk", 32'(out_div_clk), 0);
    repeat (5) step();
    chk("lost_sticky", 32'(lock_lost), 1);
    wait_run("rerun1");

    in_locked = 1'b0;
    step();
    in_locked = 1'b1;
    step();
    lock_lost_clear = 1'b1;
    step();
    lock_lost_clear = 1'b0;
    chk("set_wins", 32'(lock_lost), 1);
    chk("set_wins_rst", 32'(out_reset), 1);
    lock_lost_clear = 1'b1;
    step();
    lock_lost_clear = 1'b0;
    chk("clear", 32'(lock_lost), 0);

    in_locked = 1'b0;
    repeat (4) step();
    in_locked = 1'b1;
    repeat (3) step();
    in_locked = 1'b0;
    repeat (12) step();
    chk("filter_hold", 32'(out_reset), 1);
    in_locked = 1'b1;
    wait_run("rerun2");

    repeat (30) step();
    areset();
    chk("areset_rst", 32'(out_reset), 1);
    chk("areset_clk", 32'(out_div_clk), 0);
    repeat (2) step();
    in_reset = 1'b0;

    rcnt = 0;
    for (int k = 0; k < 3000; k++) begin
      if (in_reset) begin
        if (++rcnt >= 3) in_reset = 1'b0;
      end else if ($urandom_range(0, 499) == 0) begin
        rcnt = 0;
        areset();
      end
      if (in_locked)
        in_locked = ($urandom_range(0, 99) != 0);
      else
        in_locked = ($urandom_range(0, 3) == 0);
      lock_lost_clear = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0)
        div_enable[$urandom_range(0, ND-1)] ^= 1'b1;
      if ($urandom_range(0, 24) == 0)
        set_t(int'($urandom_range(0, ND-1)),
              int'($urandom_range(0, 7)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
